// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   PC_W / INSTR_W   : address and instruction widths
//   PC_STEP          : sequential fetch increment
//   DEFAULT_RESET_PC : default PC loaded on reset
//   fetch_entry_t    : {pc, instr} pair buffered toward decode
package fetch_pkg;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [PC_W-1:0] PC_STEP          = 64'd4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 64'h0;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk, rst      : clock, asynchronous active-high reset
//   flush_i       : drop all entries (wins over push/pop)
//   push_i        : write push_data_i at the tail (accepted if not full, or full with pop)
//   push_data_i   : entry to write
//   pop_i         : remove head entry (ignored when empty)
//   count_o       : current number of entries
//   head_valid_o  : queue is non-empty
//   head_data_o   : head entry; holds the last shown head while empty (zero after reset)
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output logic             head_valid_o,
    output fetch_entry_t     head_data_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     last_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             not_empty;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (count_q != '0);
    assign do_pop    = pop_i & not_empty;
    // A full queue can still accept a push when the head leaves in the same cycle.
    assign do_push   = push_i & ((count_q != DEPTH_C) | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (!flush_i && do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            // Remember whatever is currently on the head outputs so they can hold once empty.
            if (not_empty) begin
                last_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = not_empty;
    assign head_data_o  = not_empty ? mem_q[rd_ptr_q] : last_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the instruction-memory address,
// and buffers {pc, instruction} pairs toward decode with valid/ready back-pressure.
//   clk, rst        : clock, asynchronous active-high reset
//   busPc           : fetch address (registered PC)
//   instruction     : memory read data for busPc, same cycle
//   redirect_valid  : one-cycle pulse restarting fetch at redirect_pc
//   redirect_pc     : redirect target, low two bits forced to zero
//   out_valid       : head of queue holds a fetched instruction
//   out_ready       : decode accepts the head this cycle
//   out_instr       : instruction at head
//   out_pc          : PC of instruction at head
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    busPc,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);

    localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] count;
    logic             head_valid;
    fetch_entry_t     head_data;
    fetch_entry_t     push_data;
    logic             pop;
    logic             fetch;
    logic             unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // A handshake coincident with a redirect still counts as consumed; the flush
    // simply discards whatever remains.
    assign pop   = head_valid & out_ready;
    assign fetch = !redirect_valid & ((count < DEPTH_C) | pop);

    always_comb begin
        push_data       = '0;
        push_data.pc    = pc_q;
        push_data.instr = instruction;
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[PC_W-1:2], 2'b00};
        end else if (fetch) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (redirect_valid),
        .push_i       (fetch),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .count_o      (count),
        .head_valid_o (head_valid),
        .head_data_o  (head_data)
    );

    assign busPc     = pc_q;
    assign out_valid = head_valid;
    assign out_instr = head_data.instr;
    assign out_pc    = head_data.pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that owns the program counter and is the initiator on the instruction-memory read port. Each cycle it presents the PC on the memory address bus, captures the returned 32-bit word, and buffers {pc, instruction} pairs in a small queue toward decode. It handles decode back-pressure through a valid/ready handshake and restarts fetch on a branch/jump redirect.

## Interface

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, fetch-queue entries (power of two, ≥2).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- busPc  out  64  fetch address to instruction memory; equals the internal PC register.
- instruction  in  32  word returned by instruction memory; combinational, valid in the same cycle as busPc.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  64  redirect target; bits [1:0] ignored (forced to 0).
- out_valid  out  1  queue head holds a valid fetched instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  instruction at queue head.
- out_pc  out  64  PC of the instruction at queue head.

## Operation

- Reset (async assert): PC ← RESET_PC, queue empty, busPc = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0.
- Pop: out_valid & out_ready → head entry removed at the edge.
- Fetch condition: !redirect_valid & (count < DEPTH | pop). On fetch: push {PC, instruction}; PC ← PC + 4.
- No fetch (queue full, no pop): PC and busPc hold; instruction ignored.
- Redirect (redirect_valid = 1): queue flushed (count ← 0), PC ← {redirect_pc[63:2], 2'b00}, no push that cycle. Redirect overrides fetch and pop; an out_valid & out_ready coincident with redirect counts as consumed by decode.
- PC arithmetic: 64-bit unsigned, +4 wraps 64'hFFFF_FFFF_FFFF_FFFC → 64'h0.
- Queue is strict FIFO; out_instr/out_pc driven from head register, hold stable while out_valid & !out_ready.
- When out_valid = 0, out_instr/out_pc hold their last value (zero after reset).

## Timing

- busPc changes only at a clock edge (registered); memory read is zero-cycle.
- Fetch-to-output latency: 1 cycle (word fetched at edge N visible with out_valid at N+1).
- First out_valid = 1 in the first cycle after reset release plus one edge.
- Throughput: 1 instruction/cycle with out_ready held high; PC advances every cycle.
- Redirect latency: redirect sampled at edge N; busPc = target after N; target instruction out_valid after edge N+1 (2 cycles from redirect to valid output).
- Full queue with simultaneous pop: fetch proceeds, count unchanged.
- Reset asserted mid-operation: immediate return to reset values regardless of queue contents or pending redirect.

## Structure

- Shared package fetch_pkg: PC_W = 64, INSTR_W = 32, PC_STEP = 64'd4, DEFAULT_RESET_PC, and a packed struct fetch_entry_t {pc, instr}.
- One sub-module: fetch_queue (DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, async reset); flush has priority over push/pop.
- Top level holds PC register, fetch-condition logic, and redirect muxing.

## Test plan

- Reset with memory words 0..7 = 32'h1000_0000+i, out_ready = 1 → out_pc sequence 0,4,8,…,28 with matching out_instr, one per cycle, first valid one cycle after reset release.
- Hold out_ready = 0 for 5 cycles after reset → out_valid = 1, head stays pc 0; busPc stalls at 8 (DEPTH = 2); on release outputs 0,4,8 in order, no gaps or duplicates.
- Redirect_valid pulse with redirect_pc = 64'h103 while queue full → queue flushed, busPc = 64'h100 next cycle, next out_pc = 64'h100 two cycles after pulse; no stale entries emitted.
- PC = 64'hFFFF_FFFF_FFFF_FFF8 via redirect → out_pc sequence …FFF8, …FFFC, 64'h0.
- Async rst asserted mid-stream between edges → busPc = RESET_PC and out_valid = 0 immediately, before the next clock edge.
- Redirect coincident with out_valid & out_ready → that handshake counts once, no further old-path entries appear.
